// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM encoding
// and the store byte-enable helper.
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Reserved size falls through to a full-word enable.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SZ_B:    return 4'b0001 << addrLo;
            SZ_H:    return addrLo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/half/word lane from a memory word and
// sign- or zero-extends it to 32 bits.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byteOff,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    output logic [31:0] result
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        laneByte = word[8*byteOff +: 8];
        laneHalf = byteOff[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    result = isUnsigned ? {24'b0, laneByte} : {{24{laneByte[7]}}, laneByte};
            SZ_H:    result = isUnsigned ? {16'b0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the memory stage.
// Define DMEM_ERR_EN to report misaligned/reserved/out-of-range accesses on rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic        stall
);

    localparam int IDXW = $clog2(DEPTH_WORDS);

    state_t            stateReg;
    logic [3:0]        cntReg;
    logic              readyReg;
    logic              weReg, unsReg, errReg;
    logic [1:0]        sizeReg, offReg;
    logic [IDXW-1:0]   idxReg;
    logic [31:0]       wdataReg;
    logic [4:0]        rdReg;
    logic              rspValidReg, rspErrReg, rspWeReg, rspUnsReg;
    logic [1:0]        rspSizeReg, rspOffReg;
    logic [4:0]        rspRdReg;
    logic [31:0]       memRdReg;
    logic [31:0]       mem [0:DEPTH_WORDS-1];

    logic              accept, reqErr, enterResp;
    logic              accWe, accUns, accErr;
    logic [1:0]        accSize, accOff;
    logic [IDXW-1:0]   accIdx;
    logic [31:0]       accWdata, accLaneData, alignOut;
    logic [4:0]        accRd;
    logic [3:0]        accBe;

    assign accept = req_valid & readyReg;

`ifdef DMEM_ERR_EN
    assign reqErr = (req_size == SZ_H && req_addr[0]) ||
                    (req_size == SZ_W && req_addr[1:0] != 2'b00) ||
                    (req_size == SZ_RSV) ||
                    (req_addr[31:IDXW+2] != '0);
`else
    // Address wraps: the bits above the index are deliberately dropped.
    logic unusedAddrHi;
    assign unusedAddrHi = ^req_addr[31:IDXW+2];
    assign reqErr       = 1'b0;
`endif

    // With zero latency the array access happens on the acceptance edge itself.
    generate
        if (LATENCY == 0) begin : gDirect
            assign enterResp = accept;
            assign accWe     = req_we;
            assign accUns    = req_unsigned;
            assign accErr    = reqErr;
            assign accSize   = req_size;
            assign accOff    = req_addr[1:0];
            assign accIdx    = req_addr[IDXW+1:2];
            assign accWdata  = req_wdata;
            assign accRd     = req_rd;
        end else begin : gHeld
            assign enterResp = (stateReg == ST_WAIT) && (cntReg == 4'd0);
            assign accWe     = weReg;
            assign accUns    = unsReg;
            assign accErr    = errReg;
            assign accSize   = sizeReg;
            assign accOff    = offReg;
            assign accIdx    = idxReg;
            assign accWdata  = wdataReg;
            assign accRd     = rdReg;
        end
    endgenerate

    always_comb begin
        accBe = byte_en(accSize, accOff);
        case (accSize)
            SZ_B:    accLaneData = {4{accWdata[7:0]}};
            SZ_H:    accLaneData = {2{accWdata[15:0]}};
            default: accLaneData = accWdata;
        endcase
    end

    // Array is never reset; the reset term only blocks a commit while held in reset.
    always_ff @(posedge clk) begin
        if (enterResp && reset) begin
            if (accWe && !accErr) begin
                for (int i = 0; i < 4; i++) begin
                    if (accBe[i]) mem[accIdx][8*i +: 8] <= accLaneData[8*i +: 8];
                end
            end
            memRdReg <= mem[accIdx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg    <= ST_IDLE;
            cntReg      <= 4'd0;
            readyReg    <= 1'b1;
            weReg       <= 1'b0;
            unsReg      <= 1'b0;
            errReg      <= 1'b0;
            sizeReg     <= SZ_B;
            offReg      <= 2'b00;
            idxReg      <= '0;
            wdataReg    <= 32'd0;
            rdReg       <= 5'd0;
            rspValidReg <= 1'b0;
            rspErrReg   <= 1'b0;
            rspWeReg    <= 1'b0;
            rspUnsReg   <= 1'b0;
            rspSizeReg  <= SZ_B;
            rspOffReg   <= 2'b00;
            rspRdReg    <= 5'd0;
        end else begin
            rspValidReg <= enterResp;
            if (enterResp) begin
                rspRdReg   <= accRd;
                rspErrReg  <= accErr;
                rspWeReg   <= accWe;
                rspUnsReg  <= accUns;
                rspSizeReg <= accSize;
                rspOffReg  <= accOff;
            end
            case (stateReg)
                ST_WAIT: begin
                    if (cntReg == 4'd0) begin
                        stateReg <= ST_RESP;
                        readyReg <= 1'b1;
                    end else begin
                        cntReg <= cntReg - 4'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        weReg    <= req_we;
                        unsReg   <= req_unsigned;
                        errReg   <= reqErr;
                        sizeReg  <= req_size;
                        offReg   <= req_addr[1:0];
                        idxReg   <= req_addr[IDXW+1:2];
                        wdataReg <= req_wdata;
                        rdReg    <= req_rd;
                        if (LATENCY == 0) begin
                            stateReg <= ST_RESP;
                            readyReg <= 1'b1;
                        end else begin
                            stateReg <= ST_WAIT;
                            cntReg   <= 4'(LATENCY - 1);
                            readyReg <= 1'b0;
                        end
                    end else begin
                        stateReg <= ST_IDLE;
                        readyReg <= 1'b1;
                    end
                end
            endcase
        end
    end

    dmem_load_align uAlign (
        .word       (memRdReg),
        .byteOff    (rspOffReg),
        .size       (rspSizeReg),
        .isUnsigned (rspUnsReg),
        .result     (alignOut)
    );

    assign req_ready = readyReg;
    assign stall     = ~readyReg;
    assign rsp_valid = rspValidReg;
    assign rsp_rd    = rspRdReg;
    assign rsp_err   = rspErrReg;
    assign rsp_rdata = (rspValidReg && !rspWeReg && !rspErrReg) ? alignOut : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        req_ready, rsp_valid, rsp_err, stall;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
        .rsp_err(rsp_err), .stall(stall)
    );

    // Issues one request and returns the response; lat counts edges from acceptance (inclusive) to response, -1 on timeout.
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                             output logic [31:0] rdata, output logic [4:0] rdOut, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_size = 2'b00; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5A5A_5A5A; req_rd = ~rd;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!rsp_valid) lat = -1;
        rdata = rsp_rdata; rdOut = rsp_rd; err = rsp_err;
        $display("[TB] txn we=%0b size=%0d uns=%0b addr=%h wdata=%h rd=%0d -> rdata=%h rd=%0d err=%0b lat=%0d",
                 we, size, uns, addr, wdata, rd, rdata, rdOut, err, lat);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        tests++; if (rsp_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        tests++; if (rsp_rd !== 5'd0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rd_err got=%0d/%b exp=0/0", rsp_rd, rsp_err); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] d; logic [4:0] r; logic e; int lat;
        do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1, d, r, e, lat);
        tests++; if (lat != 3) begin fails++; $display("FAIL store_latency got=%0d exp=3", lat); end
        tests++; if (d !== 32'd0 || r !== 5'd1) begin fails++; $display("FAIL store_rsp got=%h/%0d exp=0/1", d, r); end
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rsp_pulse got=%b exp=0", rsp_valid); end
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd2, d, r, e, lat);
        tests++; if (lat != 3) begin fails++; $display("FAIL load_latency got=%0d exp=3", lat); end
        tests++; if (d !== 32'hDEADBEEF || r !== 5'd2) begin fails++; $display("FAIL load_word got=%h/%0d exp=deadbeef/2", d, r); end
    endtask

    task automatic test_byte();
        logic [31:0] d; logic [4:0] r; logic e; int lat;
        do_access(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 5'd3, d, r, e, lat);
        do_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 5'd4, d, r, e, lat);
        tests++; if (d !== 32'hFFFFFF80) begin fails++; $display("FAIL byte_signed got=%h exp=ffffff80", d); end
        do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 5'd5, d, r, e, lat);
        tests++; if (d !== 32'h00000080) begin fails++; $display("FAIL byte_unsigned got=%h exp=00000080", d); end
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd6, d, r, e, lat);
        tests++; if (d !== 32'h80ADBEEF) begin fails++; $display("FAIL byte_merge got=%h exp=80adbeef", d); end
    endtask

    task automatic test_half();
        logic [31:0] d; logic [4:0] r; logic e; int lat;
        do_access(1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, 5'd7, d, r, e, lat);
        do_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 5'd8, d, r, e, lat);
        do_access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 5'd9, d, r, e, lat);
        tests++; if (d !== 32'h00001234) begin fails++; $display("FAIL half_signed_pos got=%h exp=00001234", d); end
        do_access(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 5'd10, d, r, e, lat);
        tests++; if (d !== 32'h00007788) begin fails++; $display("FAIL half_low_unchanged got=%h exp=00007788", d); end
        do_access(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000BEEF, 5'd11, d, r, e, lat);
        do_access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 5'd12, d, r, e, lat);
        tests++; if (d !== 32'hFFFFBEEF) begin fails++; $display("FAIL half_signed_neg got=%h exp=ffffbeef", d); end
        do_access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 5'd13, d, r, e, lat);
        tests++; if (d !== 32'hFFFFFFBE) begin fails++; $display("FAIL byte_lane1 got=%h exp=ffffffbe", d); end
        do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5'd14, d, r, e, lat);
        tests++; if (d !== 32'h1234BEEF) begin fails++; $display("FAIL half_word got=%h exp=1234beef", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3]  = '{32'h10, 32'h22, 32'h13};
        logic [1:0]  sizes [3]  = '{2'b10, 2'b01, 2'b00};
        logic [4:0]  tags  [3]  = '{5'd5, 5'd9, 5'd17};
        logic [31:0] expD  [3]  = '{32'h80ADBEEF, 32'h00001234, 32'h00000080};
        int accCyc [3];
        int rspCyc [3];
        logic [4:0]  gotRd [3];
        logic [31:0] gotD  [3];
        int idx, nrsp;
        logic accepting;
        idx = 0; nrsp = 0;
        for (int i = 0; i < 3; i++) begin accCyc[i] = -1; rspCyc[i] = -1; gotRd[i] = 5'd0; gotD[i] = 32'd0; end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_unsigned = 1'b1;
        req_addr = addrs[0]; req_size = sizes[0]; req_rd = tags[0];
        for (int cyc = 0; cyc < 30 && nrsp < 3; cyc++) begin
            if (rsp_valid) begin
                rspCyc[nrsp] = cyc; gotRd[nrsp] = rsp_rd; gotD[nrsp] = rsp_rdata;
                $display("[TB] b2b rsp cyc=%0d rd=%0d rdata=%h", cyc, rsp_rd, rsp_rdata);
                nrsp++;
            end
            if (cyc <= 9) begin
                tests++;
                if (req_ready !== (cyc % 3 == 0) || stall !== !req_ready) begin
                    fails++; $display("FAIL b2b_ready cyc=%0d got=%b/%b exp=%b/%b", cyc, req_ready, stall, (cyc % 3 == 0), (cyc % 3 != 0));
                end
            end
            accepting = req_valid && req_ready;
            if (accepting) accCyc[idx] = cyc;
            @(negedge clk);
            if (accepting) begin
                idx++;
                if (idx < 3) begin req_addr = addrs[idx]; req_size = sizes[idx]; req_rd = tags[idx]; end
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (accCyc[i] != 3 * i) begin fails++; $display("FAIL b2b_accept%0d got=%0d exp=%0d", i, accCyc[i], 3 * i); end
            tests++; if (rspCyc[i] != 3 * i + 3) begin fails++; $display("FAIL b2b_rsp_cyc%0d got=%0d exp=%0d", i, rspCyc[i], 3 * i + 3); end
            tests++; if (gotRd[i] !== tags[i] || gotD[i] !== expD[i]) begin
                fails++; $display("FAIL b2b_rsp%0d got=%0d/%h exp=%0d/%h", i, gotRd[i], gotD[i], tags[i], expD[i]);
            end
        end
    endtask

    task automatic test_err();
        logic [31:0] d; logic [4:0] r; logic e; int lat;
`ifdef DMEM_ERR_EN
        do_access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 5'd20, d, r, e, lat);
        tests++; if (e !== 1'b1 || d !== 32'd0) begin fails++; $display("FAIL err_misaligned_load got=%b/%h exp=1/0", e, d); end
        tests++; if (lat != 3) begin fails++; $display("FAIL err_latency got=%0d exp=3", lat); end
        do_access(1'b1, 2'b10, 1'b0, 32'h11, 32'hCAFEF00D, 5'd21, d, r, e, lat);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL err_misaligned_store got=%b exp=1", e); end
        do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd22, d, r, e, lat);
        tests++; if (e !== 1'b0 || d !== 32'h80ADBEEF) begin fails++; $display("FAIL err_store_dropped got=%b/%h exp=0/80adbeef", e, d); end
        do_access(1'b0, 2'b10, 1'b0, 32'h410, 32'h0, 5'd23, d, r, e, lat);
        tests++; if (e !== 1'b1 || d !== 32'd0) begin fails++; $display("FAIL err_range got=%b/%h exp=1/0", e, d); end
`else
        do_access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 5'd20, d, r, e, lat);
        tests++; if (e !== 1'b0 || d !== 32'h80ADBEEF) begin fails++; $display("FAIL misaligned_ignored got=%b/%h exp=0/80adbeef", e, d); end
        do_access(1'b0, 2'b10, 1'b0, 32'h410, 32'h0, 5'd21, d, r, e, lat);
        tests++; if (e !== 1'b0 || d !== 32'h80ADBEEF) begin fails++; $display("FAIL addr_wrap got=%b/%h exp=0/80adbeef", e, d); end
        do_access(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 5'd22, d, r, e, lat);
        tests++; if (d !== 32'h1234BEEF) begin fails++; $display("FAIL rsv_as_word got=%h exp=1234beef", d); end
`endif
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic [4:0] r; logic e; int lat;
        int seen;
        do_access(1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5A5A5, 5'd7, d, r, e, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h0BADF00D; req_rd = 5'd25;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL abort_in_wait got=%b exp=1", stall); end
        reset = 1'b0;
        #1;
        tests++; if (req_ready !== 1'b1 || stall !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL abort_outputs got=%b/%b/%b exp=1/0/0", req_ready, stall, rsp_valid);
        end
        tests++; if (rsp_rd !== 5'd0 || rsp_rdata !== 32'd0) begin fails++; $display("FAIL abort_rsp got=%0d/%h exp=0/0", rsp_rd, rsp_rdata); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
        tests++; if (seen != 0) begin fails++; $display("FAIL abort_no_rsp got=%0d exp=0", seen); end
        do_access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 5'd26, d, r, e, lat);
        tests++; if (d !== 32'hA5A5A5A5) begin fails++; $display("FAIL abort_store_dropped got=%h exp=a5a5a5a5", d); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_back_to_back();
        test_err();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
